// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the five-stage pipeline control logic.
// Used by the hazard controller and its scoreboard.
package cpu_pipe_pkg;

   localparam int          REG_ADDR_W = 5;
   localparam int          NUM_REGS   = 32;
   localparam logic [31:0] NOP_IR     = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_RAW   = 2'd1,
      ST_FLUSH = 2'd2
   } pipe_state_e;

   // One squash-history slot: the destination reserved by a recent issue.
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
   } squash_entry_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/hzd_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per architectural register, plus a
// short history of recent reservations that a taken branch can revoke.
module hzd_scoreboard
   import cpu_pipe_pkg::*;
#(
   parameter int SQUASH_DEPTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic                  squash,
   output logic [NUM_REGS-1:0]   busy_map
);

   localparam logic [NUM_REGS-1:0] R0_KEEP_CLEAR = {{(NUM_REGS-1){1'b1}}, 1'b0};

   logic [NUM_REGS-1:0] busy_reg;
   logic [NUM_REGS-1:0] busy_next;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] squash_mask;
   logic [NUM_REGS-1:0] hist_mask [SQUASH_DEPTH];
   squash_entry_t       hist_reg  [SQUASH_DEPTH];
   squash_entry_t       hist_in;
   logic                set_live;

   assign set_live = set_en && (set_addr != '0);
   assign set_mask = set_live ? reg_onehot(set_addr) : '0;
   assign clr_mask = clr_en ? reg_onehot(clr_addr) : '0;
   assign hist_in  = {set_live, (set_live ? set_addr : {REG_ADDR_W{1'b0}})};

   genvar gi;
   generate
      for (gi = 0; gi < SQUASH_DEPTH; gi++) begin : g_hist_mask
         assign hist_mask[gi] = hist_reg[gi].valid ? reg_onehot(hist_reg[gi].addr) : '0;
      end
   endgenerate

   always_comb begin
      squash_mask = '0;
      for (int i = 0; i < SQUASH_DEPTH; i++) begin
         squash_mask = squash_mask | hist_mask[i];
      end
   end

   // Set is applied last so a new producer wins over a same-cycle WB clear.
   always_comb begin
      busy_next = busy_reg & ~clr_mask;
      if (squash) begin
         busy_next = busy_next & ~squash_mask;
      end
      busy_next = (busy_next | set_mask) & R0_KEEP_CLEAR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_reg <= '0;
         for (int i = 0; i < SQUASH_DEPTH; i++) begin
            hist_reg[i] <= '0;
         end
      end else begin
         busy_reg <= busy_next;
         if (squash) begin
            for (int i = 0; i < SQUASH_DEPTH; i++) begin
               hist_reg[i] <= '0;
            end
         end else begin
            hist_reg[0] <= hist_in;
            for (int i = 1; i < SQUASH_DEPTH; i++) begin
               hist_reg[i] <= hist_reg[i-1];
            end
         end
      end
   end

   assign busy_map = busy_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the IF/ID/EX/MEM/WB pipeline: RAW detection against
// the scoreboard, taken-branch flush sequencing and a saturating stall counter.
module pipe_hazard_ctrl
   import cpu_pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int SQUASH_DEPTH = 1,
   parameter int WB_BYPASS    = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic                  id_rs_use,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rt_use,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_rd_we,
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic                  br_taken,
   output logic                  issue,
   output logic                  stall_if,
   output logic                  bubble_id,
   output logic                  flush,
   output logic [NUM_REGS-1:0]   busy_map,
   output logic [1:0]            state,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   pipe_state_e         state_reg;
   pipe_state_e         state_next;
   logic [1:0]          flush_cnt_reg;
   logic [1:0]          flush_cnt_next;
   logic [CNT_W-1:0]    stall_cnt_reg;
   logic [NUM_REGS-1:0] ready_mask;
   logic [NUM_REGS-1:0] busy_eff;
   logic                rs_hzd;
   logic                rt_hzd;
   logic                raw;
   logic                issue_c;
   logic                stall_c;
   logic                bubble_c;
   logic                flush_c;

   // With bypass, a register being written back this cycle is readable in ID.
   assign ready_mask = ((WB_BYPASS != 0) && wb_we) ? reg_onehot(wb_addr) : '0;
   assign busy_eff   = busy_map & ~ready_mask;
   assign rs_hzd     = id_rs_use && busy_eff[id_rs] && (id_rs != '0);
   assign rt_hzd     = id_rt_use && busy_eff[id_rt] && (id_rt != '0);
   assign raw        = rs_hzd || rt_hzd;

   always_comb begin
      issue_c        = 1'b0;
      stall_c        = 1'b0;
      bubble_c       = 1'b1;
      flush_c        = 1'b0;
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      if (!rst) begin
         state_next     = ST_RUN;
         flush_cnt_next = '0;
      end else if (br_taken) begin
         flush_c        = 1'b1;
         state_next     = ST_FLUSH;
         flush_cnt_next = FLUSH_LOAD;
      end else begin
         case (state_reg)
            ST_FLUSH: begin
               if (flush_cnt_reg == '0) begin
                  state_next = ST_RUN;
               end else begin
                  flush_cnt_next = flush_cnt_reg - 2'd1;
               end
            end
            ST_RUN, ST_RAW: begin
               if (if_valid && raw) begin
                  stall_c    = 1'b1;
                  state_next = ST_RAW;
               end else if (if_valid) begin
                  issue_c    = 1'b1;
                  bubble_c   = 1'b0;
                  state_next = ST_RUN;
               end else begin
                  state_next = ST_RUN;
               end
            end
            default: begin
               state_next = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ST_RUN;
         flush_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
         if ((stall_c || bubble_c) && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
      end
   end

   hzd_scoreboard #(
      .SQUASH_DEPTH (SQUASH_DEPTH)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (issue_c && id_rd_we),
      .set_addr (id_rd),
      .clr_en   (wb_we),
      .clr_addr (wb_addr),
      .squash   (flush_c),
      .busy_map (busy_map)
   );

   assign issue     = issue_c;
   assign stall_if  = stall_c;
   assign bubble_id = bubble_c;
   assign flush     = flush_c;
   assign state     = state_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run, all
// checked against a behavioural model of pending registers and flush bubbles.
module tb_pipe_hazard_ctrl;

   localparam int FLUSH_CYCLES = 2;
   localparam int SQUASH_DEPTH = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, id_rs_use, id_rt_use, id_rd_we, wb_we, br_taken;
   logic [4:0]  id_rs, id_rt, id_rd, wb_addr;
   logic        issue, stall_if, bubble_id, flush;
   logic [31:0] busy_map;
   logic [1:0]  state;
   logic [15:0] stall_cnt;
   logic        issue4, stall_if4, bubble_id4, flush4;
   logic [31:0] busy_map4;
   logic [1:0]  state4;
   logic [3:0]  stall_cnt4;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .SQUASH_DEPTH(SQUASH_DEPTH),
                      .WB_BYPASS(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid),
      .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rt(id_rt), .id_rt_use(id_rt_use),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .wb_we(wb_we), .wb_addr(wb_addr),
      .br_taken(br_taken), .issue(issue), .stall_if(stall_if), .bubble_id(bubble_id),
      .flush(flush), .busy_map(busy_map), .state(state), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .SQUASH_DEPTH(SQUASH_DEPTH),
                      .WB_BYPASS(1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .if_valid(if_valid),
      .id_rs(id_rs), .id_rs_use(id_rs_use), .id_rt(id_rt), .id_rt_use(id_rt_use),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .wb_we(wb_we), .wb_addr(wb_addr),
      .br_taken(br_taken), .issue(issue4), .stall_if(stall_if4), .bubble_id(bubble_id4),
      .flush(flush4), .busy_map(busy_map4), .state(state4), .stall_cnt(stall_cnt4)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: pending producers, recent reservations, remaining bubbles.
   bit   pend [32];
   int   hist [$];
   int   bubbles_left;
   int   m_state;
   int   m_cnt16;
   int   m_cnt4;

   logic        exp_issue, exp_stall, exp_bubble, exp_flush;
   logic [31:0] exp_busy;
   logic [1:0]  exp_state;
   logic [15:0] exp_cnt16;
   logic [3:0]  exp_cnt4;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      hist.delete();
      repeat (SQUASH_DEPTH) hist.push_back(-1);
      bubbles_left = 0;
      m_state      = 0;
      m_cnt16      = 0;
      m_cnt4       = 0;
   endtask

   function automatic bit still_pending(input logic [4:0] r);
      return pend[r] && !(wb_we && (wb_addr == r));
   endfunction

   task automatic predict();
      bit hz;
      exp_issue  = 1'b0;
      exp_stall  = 1'b0;
      exp_flush  = 1'b0;
      exp_bubble = 1'b1;
      if (rst) begin
         if (br_taken) begin
            exp_flush = 1'b1;
         end else if (bubbles_left == 0 && if_valid) begin
            hz = (id_rs_use && id_rs != 0 && still_pending(id_rs)) ||
                 (id_rt_use && id_rt != 0 && still_pending(id_rt));
            if (hz) begin
               exp_stall = 1'b1;
            end else begin
               exp_issue  = 1'b1;
               exp_bubble = 1'b0;
            end
         end
      end
      for (int i = 0; i < 32; i++) exp_busy[i] = pend[i];
      exp_state = 2'(m_state);
      exp_cnt16 = 16'(m_cnt16);
      exp_cnt4  = 4'(m_cnt4);
   endtask

   task automatic model_update();
      int h;
      if (rst) begin
         if (exp_stall || exp_bubble) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (wb_we) pend[wb_addr] = 1'b0;
         if (br_taken) begin
            foreach (hist[k]) if (hist[k] >= 0) pend[hist[k]] = 1'b0;
            hist.delete();
            repeat (SQUASH_DEPTH) hist.push_back(-1);
            bubbles_left = FLUSH_CYCLES;
            m_state      = 2;
         end else begin
            if (bubbles_left > 0) begin
               bubbles_left--;
               m_state = (bubbles_left > 0) ? 2 : 0;
            end else begin
               m_state = exp_stall ? 1 : 0;
            end
            h = -1;
            if (exp_issue && id_rd_we && id_rd != 0) begin
               pend[id_rd] = 1'b1;
               h = int'(id_rd);
            end
            hist.push_front(h);
            void'(hist.pop_back());
         end
         pend[0] = 1'b0;
      end
   endtask

   task automatic tick();
      predict();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit rdwe, input bit wbwe, input int wba, input bit br);
      if_valid  = v;
      id_rs     = 5'(rs);
      id_rs_use = rsu;
      id_rt     = 5'(rt);
      id_rt_use = rtu;
      id_rd     = 5'(rd);
      id_rd_we  = rdwe;
      wb_we     = wbwe;
      wb_addr   = 5'(wba);
      br_taken  = br;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      #2;
      n_cmp++; if (issue !== 1'b0) begin n_err++; $display("FAIL rst_issue got=%b exp=0", issue); end
      n_cmp++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", stall_if); end
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got=%b exp=0", flush); end
      n_cmp++; if (bubble_id !== 1'b1) begin n_err++; $display("FAIL rst_bubble got=%b exp=1", bubble_id); end
      n_cmp++; if (busy_map !== 32'h0) begin n_err++; $display("FAIL rst_busy got=%h exp=0", busy_map); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", state); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
      tick();
      tick();
      n_cmp++; if (busy_map !== 32'h0) begin n_err++; $display("FAIL rst_hold_busy got=%h exp=0", busy_map); end
      rst = 1'b1;
      idle();
      tick();
      n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL rst_first_cnt got=%0d exp=1", stall_cnt); end
      $display("test_reset: done");
   endtask

   task automatic test_raw_stall();
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      #1;
      n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL raw_prod_issue got=%b exp=1", issue); end
      tick();
      drive(1, 4, 1, 0, 0, 6, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if ({stall_if, bubble_id, issue} !== 3'b110) begin
            n_err++; $display("FAIL raw_stall cyc=%0d got=%b exp=110", k, {stall_if, bubble_id, issue});
         end
         tick();
         n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL raw_state got=%0d exp=1", state); end
      end
      drive(1, 4, 1, 0, 0, 6, 0, 1, 4, 0);
      #1;
      n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL raw_bypass_issue got=%b exp=1", issue); end
      tick();
      n_cmp++; if (busy_map[4] !== 1'b0) begin n_err++; $display("FAIL raw_bit4_clear got=%b exp=0", busy_map[4]); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL raw_state_run got=%0d exp=0", state); end
      idle();
      $display("test_raw_stall: done");
   endtask

   task automatic test_reset_mid_run();
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      tick();
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (busy_map !== 32'h0000_0010) begin n_err++; $display("FAIL mid_pre_busy got=%h exp=00000010", busy_map); end
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL mid_pre_state got=%0d exp=1", state); end
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (busy_map !== 32'h0) begin n_err++; $display("FAIL mid_busy got=%h exp=0", busy_map); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL mid_state got=%0d exp=0", state); end
      n_cmp++; if (bubble_id !== 1'b1) begin n_err++; $display("FAIL mid_bubble got=%b exp=1", bubble_id); end
      n_cmp++; if ({issue, stall_if} !== 2'b00) begin n_err++; $display("FAIL mid_issue_stall got=%b exp=00", {issue, stall_if}); end
      n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL mid_cnt got=%0d exp=0", stall_cnt); end
      idle();
      tick();
      rst = 1'b1;
      $display("test_reset_mid_run: done");
   endtask

   task automatic test_branch_squash();
      drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 1);
      #1;
      n_cmp++; if ({flush, issue, bubble_id, stall_if} !== 4'b1010) begin
         n_err++; $display("FAIL br_outputs got=%b exp=1010", {flush, issue, bubble_id, stall_if});
      end
      tick();
      n_cmp++; if (busy_map[7] !== 1'b0) begin n_err++; $display("FAIL br_squash7 got=%b exp=0", busy_map[7]); end
      n_cmp++; if (busy_map[8] !== 1'b0) begin n_err++; $display("FAIL br_noset8 got=%b exp=0", busy_map[8]); end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < FLUSH_CYCLES; k++) begin
         #1;
         n_cmp++; if ({bubble_id, issue, flush} !== 3'b100) begin
            n_err++; $display("FAIL br_bubble cyc=%0d got=%b exp=100", k, {bubble_id, issue, flush});
         end
         tick();
      end
      #1;
      n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL br_resume got=%b exp=1", issue); end
      tick();
      idle();
      $display("test_branch_squash: done");
   endtask

   task automatic test_collision();
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      tick();
      n_cmp++; if (busy_map[5] !== 1'b1) begin n_err++; $display("FAIL col_set got=%b exp=1", busy_map[5]); end
      drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
      #1;
      n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL col_issue got=%b exp=1", issue); end
      tick();
      n_cmp++; if (busy_map[5] !== 1'b1) begin n_err++; $display("FAIL col_setwins got=%b exp=1", busy_map[5]); end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
      tick();
      n_cmp++; if (busy_map[5] !== 1'b0) begin n_err++; $display("FAIL col_clear got=%b exp=0", busy_map[5]); end
      idle();
      $display("test_collision: done");
   endtask

   task automatic test_r0_nouse();
      drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      n_cmp++; if (busy_map !== 32'h0) begin n_err++; $display("FAIL r0_busy got=%h exp=0", busy_map); end
      drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
      tick();
      drive(1, 9, 0, 9, 0, 0, 0, 0, 0, 0);
      #1;
      n_cmp++; if ({issue, stall_if} !== 2'b10) begin n_err++; $display("FAIL nouse_issue got=%b exp=10", {issue, stall_if}); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
      tick();
      idle();
      $display("test_r0_nouse: done");
   endtask

   task automatic test_saturation();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      tick();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 10) begin
            n_cmp++; if (stall_cnt4 !== 4'd10) begin n_err++; $display("FAIL sat_mid got=%0d exp=10", stall_cnt4); end
         end
      end
      n_cmp++; if (stall_cnt4 !== 4'd15) begin n_err++; $display("FAIL sat_top got=%0d exp=15", stall_cnt4); end
      n_cmp++; if (stall_cnt !== 16'd20) begin n_err++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
      tick();
      tick();
      n_cmp++; if (stall_cnt4 !== 4'd15) begin n_err++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt4); end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
      tick();
      idle();
      $display("test_saturation: done");
   endtask

   task automatic test_random();
      for (int c = 0; c < 250; c++) begin
         drive(($urandom_range(0, 99) < 85), $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
               ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 35),
               $urandom_range(0, 7), ($urandom_range(0, 99) < 5));
         #1;
         predict();
         $display("rnd %0d: v=%b rs=%0d/%b rt=%0d/%b rd=%0d/%b wb=%b/%0d br=%b -> iss=%b stl=%b bub=%b fl=%b st=%0d busy=%h",
                  c, if_valid, id_rs, id_rs_use, id_rt, id_rt_use, id_rd, id_rd_we, wb_we, wb_addr,
                  br_taken, issue, stall_if, bubble_id, flush, state, busy_map);
         n_cmp++; if (issue !== exp_issue) begin n_err++; $display("FAIL rnd_issue cyc=%0d got=%b exp=%b", c, issue, exp_issue); end
         n_cmp++; if (stall_if !== exp_stall) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall_if, exp_stall); end
         n_cmp++; if (bubble_id !== exp_bubble) begin n_err++; $display("FAIL rnd_bubble cyc=%0d got=%b exp=%b", c, bubble_id, exp_bubble); end
         n_cmp++; if (flush !== exp_flush) begin n_err++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", c, flush, exp_flush); end
         n_cmp++; if (busy_map !== exp_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", c, busy_map, exp_busy); end
         n_cmp++; if (state !== exp_state) begin n_err++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", c, state, exp_state); end
         n_cmp++; if (stall_cnt !== exp_cnt16) begin n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, exp_cnt16); end
         n_cmp++; if (stall_cnt4 !== exp_cnt4) begin n_err++; $display("FAIL rnd_cnt4 cyc=%0d got=%0d exp=%0d", c, stall_cnt4, exp_cnt4); end
         tick();
      end
      idle();
      $display("test_random: done");
   endtask

   initial begin
      idle();
      test_reset();
      test_raw_stall();
      test_reset_mid_run();
      test_branch_squash();
      test_collision();
      test_r0_nouse();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the five-stage IF/ID/EX/MEM/WB pipeline. It replaces ad-hoc hazard counting.
- Holds a register scoreboard of pending writebacks and detects RAW hazards for the instruction entering ID.
- Drives IF stall, ID bubble (NOP) insertion and taken-branch flush.
- Sits beside the stage registers. It consumes decoded ID fields, the WB write port and the EX branch outcome.

Parameters:
- FLUSH_CYCLES, 2, number of ID bubbles inserted after a taken branch (range 1..3).
- SQUASH_DEPTH, 1, number of most-recent issues whose scoreboard reservations a taken branch revokes (range 1..2).
- WB_BYPASS, 1, 1 = a register cleared by WB in the current cycle counts as ready (register file writes before it is read).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- if_valid  input  1  IF presents a real instruction to ID this cycle.
- id_rs  input  5  source register 1 of the instruction entering ID.
- id_rs_use  input  1  id_rs is read.
- id_rt  input  5  source register 2.
- id_rt_use  input  1  id_rt is read.
- id_rd  input  5  destination register.
- id_rd_we  input  1  instruction writes id_rd.
- wb_we  input  1  WB writes the register file this cycle.
- wb_addr  input  5  WB destination.
- br_taken  input  1  EX resolved a taken branch this cycle.
- issue  output  1  instruction enters ID this cycle.
- stall_if  output  1  hold PC and IF register.
- bubble_id  output  1  ID latches NOP 32'hFFFF_FFFF instead of IF output.
- flush  output  1  taken-branch squash pulse.
- busy_map  output  32  scoreboard pending bits (debug).
- state  output  2  FSM state.
- stall_cnt  output  CNT_W  saturating count of cycles with stall_if or bubble_id.

Behaviour:
- Reset (rst=0, async):
  - busy_map=0, squash history=0, state=RUN, flush counter=0, stall_cnt=0.
  - While rst=0: issue=0, stall_if=0, flush=0, bubble_id=1.
- FSM states: RUN=0, RAW=1, FLUSH=2. Encoding 3 is illegal and recovers to RUN on the next edge.
- Hazard term: raw = (id_rs_use & busy[id_rs] & id_rs!=0) | (id_rt_use & busy[id_rt] & id_rt!=0).
  - When WB_BYPASS=1, busy[x] is masked by ~(wb_we & wb_addr==x).
- Priority per cycle: br_taken > raw > issue.
- br_taken=1 (any state):
  - Combinational outputs: flush=1, issue=0, bubble_id=1, stall_if=0.
  - Next state FLUSH; flush counter loads FLUSH_CYCLES-1.
  - Every valid squash-history entry clears its busy bit; history cleared.
- FLUSH:
  - bubble_id=1, issue=0, stall_if=0.
  - Counter decrements each cycle; at 0, next state is RUN.
  - Result: exactly FLUSH_CYCLES bubbles after the flush cycle.
  - br_taken during FLUSH reloads the counter.
- RUN/RAW with no br_taken:
  - raw & if_valid: stall_if=1, bubble_id=1, issue=0, next state RAW.
  - ~raw & if_valid: issue=1, next state RUN.
  - ~if_valid: bubble_id=1, issue=0, next state RUN.
- On issue with id_rd_we & id_rd!=0:
  - Set busy[id_rd].
  - Shift {1,id_rd} into history; otherwise shift {0,x}.
  - History also shifts {0,x} on any non-issue cycle.
- WB clear: wb_we clears busy[wb_addr].
- Simultaneous set and WB clear of the same register: set wins (new producer).
- Simultaneous squash and set cannot occur (br_taken blocks issue).
- Register 0 is never marked busy.
- stall_cnt increments when stall_if|bubble_id and rst=1. It saturates at all-ones and does not wrap.
- All state is updated on the rising clk edge.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - state enum (RUN/RAW/FLUSH);
  - NOP_IR=32'hFFFF_FFFF;
  - REG_ADDR_W=5;
  - NUM_REGS=32.
- One sub-module, hzd_scoreboard: 32-bit busy array with set port, WB clear port, squash-history shift register and squash port. It outputs busy_map.
- The FSM, hazard compare and counters stay in pipe_hazard_ctrl.

Test Plan:
- Reset mid-run: drive busy_map=0x0000_0010, state=RAW, then pulse rst=0 asynchronously → busy_map=0, state=0, bubble_id=1 immediately, with no clk edge required.
- RAW stall: issue rd=4 (we), next cycle rs=4 used → stall_if=1, bubble_id=1, state=1. Hold until wb_we=1, wb_addr=4. In that cycle issue=1 (WB_BYPASS=1) and busy_map bit4 clears.
- Taken-branch squash: issue rd=7, next cycle br_taken=1 → flush=1 for one cycle, busy_map bit7 cleared, then exactly 2 cycles bubble_id=1 with issue=0, then issue=1 resumes.
- Set/clear collision: busy[5]=1, same cycle wb_we=1, wb_addr=5 and issue rd=5 we → busy_map bit5 remains 1.
- r0 and no-use operands: issue rd=0 we=1 → busy_map unchanged. rs=9 with id_rs_use=0 while busy[9]=1 → issue=1, no stall.
- Counter saturation: force CNT_W=4, hold stall for 20 cycles → stall_cnt=15 and stays at 15.
